// File: rtl/arithmetic_logic_unit_pkg.sv
// Shared constants for the integer execution unit and its callers.
// Holds the instruction-type and ROB-index widths and the decoded
// operation-code encodings. This includes the immediate/upper/jump codes
// that the reservation station remaps before issue.
package arithmetic_logic_unit_pkg;

  localparam int unsigned TYPE_BIT      = 6;
  localparam int unsigned ROB_INDEX_BIT = 4;

  // Register/register arithmetic and logic
  localparam logic [TYPE_BIT-1:0] ADD   = 6'd1;
  localparam logic [TYPE_BIT-1:0] SUB   = 6'd2;
  localparam logic [TYPE_BIT-1:0] SLL   = 6'd3;
  localparam logic [TYPE_BIT-1:0] SLT   = 6'd4;
  localparam logic [TYPE_BIT-1:0] SLTU  = 6'd5;
  localparam logic [TYPE_BIT-1:0] XOR   = 6'd6;
  localparam logic [TYPE_BIT-1:0] SRL   = 6'd7;
  localparam logic [TYPE_BIT-1:0] SRA   = 6'd8;
  localparam logic [TYPE_BIT-1:0] OR    = 6'd9;
  localparam logic [TYPE_BIT-1:0] AND   = 6'd10;

  // Conditional branches (result is the taken flag)
  localparam logic [TYPE_BIT-1:0] BEQ   = 6'd11;
  localparam logic [TYPE_BIT-1:0] BNE   = 6'd12;
  localparam logic [TYPE_BIT-1:0] BLT   = 6'd13;
  localparam logic [TYPE_BIT-1:0] BGE   = 6'd14;
  localparam logic [TYPE_BIT-1:0] BLTU  = 6'd15;
  localparam logic [TYPE_BIT-1:0] BGEU  = 6'd16;
  localparam logic [TYPE_BIT-1:0] JALR  = 6'd17;

  // Immediate/upper/jump forms; the caller remaps these to base codes
  localparam logic [TYPE_BIT-1:0] ADDI  = 6'd18;
  localparam logic [TYPE_BIT-1:0] SLTI  = 6'd19;
  localparam logic [TYPE_BIT-1:0] SLTIU = 6'd20;
  localparam logic [TYPE_BIT-1:0] XORI  = 6'd21;
  localparam logic [TYPE_BIT-1:0] ORI   = 6'd22;
  localparam logic [TYPE_BIT-1:0] ANDI  = 6'd23;
  localparam logic [TYPE_BIT-1:0] SLLI  = 6'd24;
  localparam logic [TYPE_BIT-1:0] SRLI  = 6'd25;
  localparam logic [TYPE_BIT-1:0] SRAI  = 6'd26;
  localparam logic [TYPE_BIT-1:0] LUI   = 6'd27;
  localparam logic [TYPE_BIT-1:0] AUIPC = 6'd28;
  localparam logic [TYPE_BIT-1:0] JAL   = 6'd29;

endpackage

// File: rtl/arithmetic_logic_unit.sv
// Single-cycle integer execution unit.
// Computes one RV32I arithmetic, branch-compare or JALR-target operation per
// request and registers the result, its ROB tag and a valid strobe for
// write-back on the next rising edge.
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous active-high reset
//   rdy_in      global ready; low stalls and holds every output
//   inst_type   decoded operation code
//   req         execute request, already qualified by the caller
//   r1, r2      operands (rs1, rs2 or immediate)
//   rob_id_in   ROB tag of the requesting entry
//   ready       registered result-valid strobe
//   rob_id_out  registered tag for the result
//   result      registered computed value
module arithmetic_logic_unit
  import arithmetic_logic_unit_pkg::*;
#(
  parameter int unsigned TYPE_BIT      = arithmetic_logic_unit_pkg::TYPE_BIT,
  parameter int unsigned ROB_INDEX_BIT = arithmetic_logic_unit_pkg::ROB_INDEX_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic [TYPE_BIT-1:0]      inst_type,
  input  logic                     req,
  input  logic [31:0]              r1,
  input  logic [31:0]              r2,
  input  logic [ROB_INDEX_BIT-1:0] rob_id_in,
  output logic                     ready,
  output logic [ROB_INDEX_BIT-1:0] rob_id_out,
  output logic [31:0]              result
);

  logic                     ready_q;
  logic [ROB_INDEX_BIT-1:0] rob_id_q;
  logic [31:0]              result_q;
  logic [31:0]              result_d;

  logic [4:0]  shamt;
  logic [31:0] sum;
  logic        lt_s;
  logic        lt_u;
  logic        eq;

  assign shamt = r2[4:0];
  assign sum   = r1 + r2;
  assign lt_s  = $signed(r1) < $signed(r2);
  assign lt_u  = r1 < r2;
  assign eq    = r1 == r2;

  always_comb begin
    result_d = '0;
    case (inst_type)
      ADD:     result_d = sum;
      SUB:     result_d = r1 - r2;
      SLL:     result_d = r1 << shamt;
      SLT:     result_d = {31'b0, lt_s};
      SLTU:    result_d = {31'b0, lt_u};
      XOR:     result_d = r1 ^ r2;
      SRL:     result_d = r1 >> shamt;
      SRA:     result_d = $unsigned($signed(r1) >>> shamt);
      OR:      result_d = r1 | r2;
      AND:     result_d = r1 & r2;
      BEQ:     result_d = {31'b0, eq};
      BNE:     result_d = {31'b0, ~eq};
      BLT:     result_d = {31'b0, lt_s};
      BGE:     result_d = {31'b0, ~lt_s};
      BLTU:    result_d = {31'b0, lt_u};
      BGEU:    result_d = {31'b0, ~lt_u};
      JALR:    result_d = {sum[31:1], 1'b0};
      // Unknown codes still strobe ready so the ROB entry retires.
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ready_q  <= 1'b0;
      rob_id_q <= '0;
      result_q <= '0;
    end else if (rdy_in) begin
      ready_q <= req;
      // Tag and result are don't-care when ready is low, so hold them.
      if (req) begin
        rob_id_q <= rob_id_in;
        result_q <= result_d;
      end
    end
  end

  assign ready      = ready_q;
  assign rob_id_out = rob_id_q;
  assign result     = result_q;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
module tb_arithmetic_logic_unit;
  import arithmetic_logic_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  inst_type;
  logic        req;
  logic [31:0] r1, r2;
  logic [3:0]  rob_id_in;
  logic        ready;
  logic [3:0]  rob_id_out;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  arithmetic_logic_unit dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .inst_type  (inst_type),
    .req        (req),
    .r1         (r1),
    .r2         (r2),
    .rob_id_in  (rob_id_in),
    .ready      (ready),
    .rob_id_out (rob_id_out),
    .result     (result)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic er, input logic [3:0] et,
                         input logic [31:0] ev);
    chk({name, ".ready"}, {31'b0, ready}, {31'b0, er});
    chk({name, ".tag"}, {28'b0, rob_id_out}, {28'b0, et});
    chk({name, ".result"}, result, ev);
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    req = 1'b1; inst_type = op; r1 = a; r2 = b; rob_id_in = tag;
  endtask

  // Reference model taken from the operation rules using plain arithmetic.
  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned ua = a, ub = b;
    longint signed   sa = $signed(a), sb = $signed(b);
    int sh = int'(b % 32);
    longint signed   q;
    case (op)
      ADD:  return 32'((ua + ub) % 64'h1_0000_0000);
      SUB:  return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      SLL:  return 32'((ua * (64'd1 << sh)) % 64'h1_0000_0000);
      SRL:  return 32'(ua / (64'd1 << sh));
      SRA: begin
        // Floor division by 2^sh is an arithmetic shift.
        q = sa / (longint'(1) << sh);
        if (sa < 0 && (sa % (longint'(1) << sh)) != 0) q = q - 1;
        return 32'(q);
      end
      SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      SLTU: return (ua < ub) ? 32'd1 : 32'd0;
      XOR:  return a ^ b;
      OR:   return a | b;
      AND:  return a & b;
      BEQ:  return (ua == ub) ? 32'd1 : 32'd0;
      BNE:  return (ua != ub) ? 32'd1 : 32'd0;
      BLT:  return (sa < sb) ? 32'd1 : 32'd0;
      BGE:  return (sa >= sb) ? 32'd1 : 32'd0;
      BLTU: return (ua < ub) ? 32'd1 : 32'd0;
      BGEU: return (ua >= ub) ? 32'd1 : 32'd0;
      JALR: return 32'(((ua + ub) % 64'h1_0000_0000) / 2 * 2);
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [5:0] ops [20];
    logic       e_ready;
    logic [3:0] e_tag;
    logic [31:0] e_res;

    ops = '{ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU,
            BGEU, JALR, ADDI, 6'h3F, 6'd0};

    rst_in = 1'b1; rdy_in = 1'b1; req = 1'b0; inst_type = '0;
    r1 = '0; r2 = '0; rob_id_in = '0;
    step();
    chk_out("reset", 1'b0, 4'd0, 32'd0);
    rst_in = 1'b0;

    // Load nonzero state, then reset between edges: clears before the next edge.
    issue(ADD, 32'd10, 32'd20, 4'd9);
    step();
    chk_out("preload", 1'b1, 4'd9, 32'd30);
    #2 rst_in = 1'b1;
    #1 chk_out("async_reset", 1'b0, 4'd0, 32'd0);
    step();
    rst_in = 1'b0; req = 1'b0;
    step();
    chk_out("post_reset_idle", 1'b0, 4'd0, 32'd0);

    // Arithmetic back-to-back sequence
    issue(ADD, 32'hFFFF_FFFF, 32'd1, 4'd1);
    step(); chk_out("add_wrap", 1'b1, 4'd1, 32'd0);
    issue(SUB, 32'd3, 32'd5, 4'd2);
    step(); chk_out("sub_neg", 1'b1, 4'd2, 32'hFFFF_FFFE);
    issue(SRA, 32'h8000_0000, 32'h24, 4'd3);
    step(); chk_out("sra_amt", 1'b1, 4'd3, 32'hF800_0000);

    // Table-driven single-cycle vectors
    vecs.push_back('{"slt",  SLT,  32'hFFFF_FFFF, 32'd1, 4'd4, 32'd1});
    vecs.push_back('{"sltu", SLTU, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd0});
    vecs.push_back('{"blt",  BLT,  32'hFFFF_FFFF, 32'd1, 4'd6, 32'd1});
    vecs.push_back('{"bgeu", BGEU, 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd1});
    vecs.push_back('{"beq",  BEQ,  32'hFFFF_FFFF, 32'd1, 4'd8, 32'd0});
    vecs.push_back('{"bne",  BNE,  32'hFFFF_FFFF, 32'd1, 4'd9, 32'd1});
    vecs.push_back('{"bge",  BGE,  32'hFFFF_FFFF, 32'd1, 4'd10, 32'd0});
    vecs.push_back('{"bltu", BLTU, 32'hFFFF_FFFF, 32'd1, 4'd11, 32'd0});
    vecs.push_back('{"sll",  SLL,  32'h0000_0003, 32'hFFFF_FFE4, 4'd12, 32'h0000_0030});
    vecs.push_back('{"srl",  SRL,  32'h8000_0000, 32'd31, 4'd13, 32'd1});
    vecs.push_back('{"xor",  XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 4'd14, 32'hFF00_EDCB});
    vecs.push_back('{"or",   OR,   32'hF000_0001, 32'h0F00_0010, 4'd15, 32'hFF00_0011});
    vecs.push_back('{"and",  AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0, 32'hF000_F000});
    vecs.push_back('{"unknown", 6'h3F, 32'h1234_5678, 32'h9, 4'd5, 32'd0});
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      step();
      chk_out(vecs[i].name, 1'b1, vecs[i].tag, vecs[i].exp);
    end

    // JALR single request: one-cycle strobe
    issue(JALR, 32'h1001, 32'd4, 4'd3);
    step(); chk_out("jalr", 1'b1, 4'd3, 32'h1004);
    req = 1'b0;
    step(); chk({"jalr_strobe_end"}, {31'b0, ready}, 32'd0);

    // Stall holds everything, including high ready
    issue(ADD, 32'd2, 32'd2, 4'd7);
    step(); chk_out("stall_issue", 1'b1, 4'd7, 32'd4);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(SUB, 32'd100 + 32'(i), 32'd1, 4'(i + 1));
      step(); chk_out("stall_hold", 1'b1, 4'd7, 32'd4);
    end
    rdy_in = 1'b1; req = 1'b0;
    step(); chk({"stall_release"}, {31'b0, ready}, 32'd0);

    // Reset with a request pending: no strobe for it
    issue(ADD, 32'd1, 32'd1, 4'd2);
    #2 rst_in = 1'b1;
    step(); chk_out("reset_pending", 1'b0, 4'd0, 32'd0);
    rst_in = 1'b0; req = 1'b0;
    step(); chk({"reset_pending_idle"}, {31'b0, ready}, 32'd0);

    // Randomized traffic against the model
    e_ready = 1'b0; e_tag = 4'd0; e_res = 32'd0;
    for (int n = 0; n < 400; n++) begin
      req       = ($urandom_range(0, 3) != 0);
      rdy_in    = ($urandom_range(0, 4) != 0);
      inst_type = ops[$urandom_range(0, 19)];
      r1        = $urandom();
      r2        = ($urandom_range(0, 3) == 0) ? r1 : $urandom();
      if ($urandom_range(0, 5) == 0) r2 = 32'(1 << $urandom_range(0, 31));
      rob_id_in = 4'($urandom());
      if (rdy_in) begin
        e_ready = req;
        if (req) begin
          e_tag = rob_id_in;
          e_res = model(inst_type, r1, r2);
        end
      end
      step();
      chk_out("random", e_ready, e_tag, e_res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
